// File: rtl/sgf_round_phase.sv
// sgf_round_phase: multi-cycle IEEE-754 significand rounding stage.
// Captures a normalized significand with guard/sticky/sign and rounding mode,
// decides the increment, then produces a one-bit-wider post-round significand.
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   start             request, sampled only in IDLE
//   Sgf_F             normalized significand (W_Sgf+1 bits incl. hidden bit)
//   guard, sticky     rounding bits below the LSB of Sgf_F
//   sign              result sign (1 = negative)
//   round_mode        00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
//   Sgf_PR            post-round significand, MSB is carry-out
//   renorm            carry-out set; result needs renormalization
//   inexact           guard | sticky of the rounded operation
//   busy              high in DECIDE, ADD and DONE
//   done              one-cycle pulse while Sgf_PR is first valid
module sgf_round_phase #(
  parameter int unsigned W_Sgf = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [W_Sgf:0]     Sgf_F,
  input  logic               guard,
  input  logic               sticky,
  input  logic               sign,
  input  logic [1:0]         round_mode,
  output logic [W_Sgf+1:0]   Sgf_PR,
  output logic               renorm,
  output logic               inexact,
  output logic               busy,
  output logic               done
);

  localparam int unsigned W_IN  = W_Sgf + 1;
  localparam int unsigned W_OUT = W_Sgf + 2;

  typedef enum logic [1:0] {IDLE, DECIDE, ADD, DONE} state_t;

  state_t            state;
  logic [W_IN-1:0]   sgf_q;
  logic              guard_q;
  logic              sticky_q;
  logic              sign_q;
  logic [1:0]        mode_q;
  logic              inc;
  logic              inc_c;
  logic [W_OUT-1:0]  sum_c;

  // Increment decision from the captured operands.
  always_comb begin
    inc_c = 1'b0;
    case (mode_q)
      2'b00:   inc_c = guard_q & (sticky_q | sgf_q[0]);
      2'b01:   inc_c = 1'b0;
      2'b10:   inc_c = ~sign_q & (guard_q | sticky_q);
      default: inc_c = sign_q & (guard_q | sticky_q);
    endcase
  end

  // Full-width add so the carry lands in the MSB instead of being dropped.
  assign sum_c = {1'b0, sgf_q} + W_OUT'(inc);

  // Sequencer with registered outputs; busy/done are pure state decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sgf_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      sign_q   <= 1'b0;
      mode_q   <= 2'b00;
      inc      <= 1'b0;
      Sgf_PR   <= '0;
      renorm   <= 1'b0;
      inexact  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sgf_q    <= Sgf_F;
            guard_q  <= guard;
            sticky_q <= sticky;
            sign_q   <= sign;
            mode_q   <= round_mode;
            busy     <= 1'b1;
            state    <= DECIDE;
          end
        end
        DECIDE: begin
          inc   <= inc_c;
          state <= ADD;
        end
        ADD: begin
          Sgf_PR  <= sum_c;
          renorm  <= sum_c[W_OUT-1];
          inexact <= guard_q | sticky_q;
          done    <= 1'b1;
          state   <= DONE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sgf_round_phase.sv
// tb_sgf_round_phase: directed scoreboard bench for sgf_round_phase (W_Sgf=23).
module tb_sgf_round_phase;

  typedef struct packed {
    logic [24:0] pr;
    logic        rn;
    logic        ix;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] Sgf_F;
  logic        guard;
  logic        sticky;
  logic        sign;
  logic [1:0]  round_mode;
  logic [24:0] Sgf_PR;
  logic        renorm;
  logic        inexact;
  logic        busy;
  logic        done;

  int   total;
  int   passed;
  int   dones;
  exp_t sb[$];

  sgf_round_phase #(.W_Sgf(23)) dut (
    .clk(clk), .rst(rst), .start(start), .Sgf_F(Sgf_F), .guard(guard),
    .sticky(sticky), .sign(sign), .round_mode(round_mode), .Sgf_PR(Sgf_PR),
    .renorm(renorm), .inexact(inexact), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference rounding model.
  function automatic exp_t model(input logic [23:0] f, input logic g, input logic s,
                                 input logic sg, input logic [1:0] m);
    exp_t e;
    logic up;
    logic [24:0] r;
    case (m)
      2'b00:   up = g && (s || f[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = !sg && (g || s);
      default: up = sg && (g || s);
    endcase
    r    = {1'b0, f} + (up ? 25'd1 : 25'd0);
    e.pr = r;
    e.rn = r[24];
    e.ix = g || s;
    return e;
  endfunction

  // Scoreboard side: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      dones++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("Sgf_PR", 32'(Sgf_PR), 32'(e.pr));
        chk("renorm", 32'(renorm), 32'(e.rn));
        chk("inexact", 32'(inexact), 32'(e.ix));
      end
    end
  end

  task automatic drive(input logic [23:0] f, input logic g, input logic s,
                       input logic sg, input logic [1:0] m);
    Sgf_F = f; guard = g; sticky = s; sign = sg; round_mode = m;
  endtask

  task automatic scramble();
    Sgf_F = 24'($urandom); guard = 1'($urandom); sticky = 1'($urandom);
    sign = 1'($urandom); round_mode = 2'($urandom);
  endtask

  // One full operation with latency/timing checks; caller starts from just after an edge in IDLE.
  task automatic op(input string tag, input logic [23:0] f, input logic g, input logic s,
                    input logic sg, input logic [1:0] m);
    exp_t e;
    e = model(f, g, s, sg, m);
    sb.push_back(e);
    drive(f, g, s, sg, m);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    chk({tag, "_busy_k"}, 32'(busy), 32'd1);
    chk({tag, "_done_k"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_k1"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_k2"}, 32'(done), 32'd1);
    chk({tag, "_busy_k2"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_done_k3"}, 32'(done), 32'd0);
    chk({tag, "_busy_k3"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, 32'(Sgf_PR), 32'(e.pr));
  endtask

  initial begin
    int d0;
    logic [11:0] seen;
    total = 0; passed = 0; dones = 0;
    rst = 1'b1; start = 1'b0;
    drive(24'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    #3;
    chk("rst_Sgf_PR", 32'(Sgf_PR), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", {30'd0, renorm, inexact}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    op("ne_carry", 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 2'b00);
    chk("ne_carry_renorm", 32'(renorm), 32'd1);
    chk("ne_carry_pr", 32'(Sgf_PR), 32'h1000000);
    op("tie_even", 24'h800000, 1'b1, 1'b0, 1'b0, 2'b00);
    chk("tie_even_pr", 32'(Sgf_PR), 32'h0800000);
    op("tie_odd", 24'h800001, 1'b1, 1'b0, 1'b0, 2'b00);
    chk("tie_odd_pr", 32'(Sgf_PR), 32'h0800002);
    op("rz", 24'hC00000, 1'b0, 1'b1, 1'b0, 2'b01);
    op("rp_pos", 24'hC00000, 1'b0, 1'b1, 1'b0, 2'b10);
    chk("rp_pos_pr", 32'(Sgf_PR), 32'h0C00001);
    op("rp_neg", 24'hC00000, 1'b0, 1'b1, 1'b1, 2'b10);
    op("rm_neg", 24'hC00000, 1'b0, 1'b1, 1'b1, 2'b11);
    chk("rm_neg_pr", 32'(Sgf_PR), 32'h0C00001);
    op("rm_pos", 24'hC00000, 1'b0, 1'b1, 1'b0, 2'b11);
    op("rz_all1", 24'hFFFFFF, 1'b1, 1'b1, 1'b1, 2'b01);
    chk("rz_all1_renorm", 32'(renorm), 32'd0);
    for (int m = 0; m < 4; m++) begin
      op("exact", 24'hABCDEF, 1'b0, 1'b0, 1'(m), 2'(m));
      chk("exact_inexact", 32'(inexact), 32'd0);
    end

    // start re-pulsed while busy is ignored
    d0 = dones;
    sb.push_back(model(24'h800001, 1'b1, 1'b0, 1'b0, 2'b00));
    drive(24'h800001, 1'b1, 1'b0, 1'b0, 2'b00);
    start = 1'b1;
    @(posedge clk); #1;
    drive(24'hFFFFFF, 1'b1, 1'b1, 1'b0, 2'b10);
    @(posedge clk); #1;
    drive(24'h123456, 1'b0, 1'b1, 1'b1, 2'b11);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; end
    chk("ignore_done_count", 32'(dones - d0), 32'd1);

    // start held high: one accept every 4 cycles
    for (int i = 0; i < 3; i++) sb.push_back(model(24'h7FFFFF, 1'b1, 1'b1, 1'b1, 2'b11));
    drive(24'h7FFFFF, 1'b1, 1'b1, 1'b1, 2'b11);
    start = 1'b1;
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      seen[i] = done;
      if (i == 8) start = 1'b0;
    end
    chk("held_done_pattern", 32'(seen), 32'h444);

    // reset mid-operation aborts with no done
    d0 = dones;
    sb.push_back(model(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 2'b00));
    drive(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 2'b00);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_Sgf_PR", 32'(Sgf_PR), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_flags", {29'd0, renorm, inexact, done}, 32'd0);
    void'(sb.pop_back());
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk("mid_rst_no_done", 32'(dones - d0), 32'd0);
    op("post_rst", 24'h800001, 1'b1, 1'b0, 1'b0, 2'b00);
    chk("post_rst_pr", 32'(Sgf_PR), 32'h0800002);

    @(posedge clk); #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sgf_round_phase.md
# sgf_round_phase

Multi-cycle significand rounding stage for the floating-point multiplier datapath. It takes the normalized significand produced by the normalization phase, together with the guard and sticky bits and the sign, and applies the selected IEEE-754 rounding mode. It returns a post-round significand one bit wider, including the carry-out. When that carry-out is set, `renorm` tells the controller to route the result back through the normalization phase, which shifts it right and bumps the exponent.

## Interface
- `W_Sgf`, 23, stored fraction width (23 single, 52 double); significand input is `W_Sgf+1` bits including hidden bit
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `Sgf_F`  in  `W_Sgf+1`  normalized significand awaiting rounding
- `guard`  in  1  first bit below LSB of `Sgf_F`
- `sticky`  in  1  OR of all bits below `guard`
- `sign`  in  1  result sign (1 = negative)
- `round_mode`  in  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
- `Sgf_PR`  out  `W_Sgf+2`  post-round significand; MSB is carry-out
- `renorm`  out  1  equals `Sgf_PR[W_Sgf+1]`; result needs renormalization and exponent update
- `inexact`  out  1  `guard | sticky` of the rounded operation
- `busy`  out  1  high in DECIDE, ADD and DONE
- `done`  out  1  one-cycle pulse; result valid

## Operation
- FSM has four states: IDLE, DECIDE, ADD, DONE.
  - IDLE -> DECIDE on `start`=1. The same edge registers `Sgf_F`, `guard`, `sticky`, `sign` and `round_mode`.
  - DECIDE -> ADD unconditionally. The edge registers the increment bit `inc`.
  - ADD -> DONE unconditionally. The edge registers `Sgf_PR`, `renorm` and `inexact`.
  - DONE -> IDLE unconditionally.
- Increment rule, using registered operands:
  - mode 00: `inc = guard & (sticky | Sgf_F[0])`
  - mode 01: `inc = 0`
  - mode 10: `inc = ~sign & (guard | sticky)`
  - mode 11: `inc = sign & (guard | sticky)`
- Arithmetic: `Sgf_PR = {1'b0, Sgf_F} + inc`, computed at `W_Sgf+2` bits with no truncation. `renorm` is the MSB of that sum. The sum overflows into the MSB only when `Sgf_F` is all ones and `inc`=1; the result is then exactly `1 << (W_Sgf+1)`.
- `inexact = guard | sticky`, independent of mode.
- `start` while `busy`=1 is ignored. No queuing, and the in-flight operation is unaffected.
- `Sgf_PR`, `renorm` and `inexact` hold their values from the ADD-edge update until the next operation's ADD edge.
- Input ports may change after the accepting edge without effect on the in-flight operation.

## Timing
- Reset:
  - State goes to IDLE.
  - `Sgf_PR`, `renorm`, `inexact`, `busy`, `done` and the internal `inc` all go to 0.
  - Takes effect immediately, without a clock edge.
- Reset asserted mid-operation aborts it. No `done` pulse is produced. The first `start` after reset release is accepted normally.
- Latency: `start` is sampled at edge k. `busy` is high from k to k+3. `done` is high for the single cycle between edges k+2 and k+3, and `Sgf_PR` is valid in that same cycle.
- Throughput: one operation per 4 cycles. A `start` held high in the DONE cycle is not sampled; it is accepted at edge k+4 if still high in IDLE.
- `busy` and `done` are registered state decodes with no combinational path from `start`.

## Test plan
- Nearest-even, carry case (`W_Sgf`=23): `Sgf_F`=24'hFFFFFF, guard=1, sticky=0, mode 00 -> `Sgf_PR`=25'h1000000, `renorm`=1, `inexact`=1. `done` pulses exactly at k+2..k+3.
- Ties to even: `Sgf_F`=24'h800000, g=1, s=0, mode 00 -> 25'h0800000, `renorm`=0, `inexact`=1. With `Sgf_F`=24'h800001 -> 25'h0800002.
- Directed modes, `Sgf_F`=24'hC00000, g=0, s=1:
  - mode 01 -> 25'h0C00000
  - mode 10 with sign=0 -> 25'h0C00001
  - mode 10 with sign=1 -> 25'h0C00000
  - mode 11 with sign=1 -> 25'h0C00001
- Exact input: g=0, s=0 in every mode -> `Sgf_PR` = `{0, Sgf_F}`, `inexact`=0.
- Protocol: pulse `start` again at k+1 and k+2 with different operands -> the result reflects only the first operand, and exactly one `done` is produced. Hold `start` high continuously -> `done` repeats every 4 cycles.
- Reset: assert `rst` between edges k+1 and k+2 -> outputs read 0 immediately and no `done` pulse follows. After release, a new `start` completes with correct `Sgf_PR`.
